univ_reg: RTL
=============

UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 10: register width in bits, legal range 2..64.
REQ-002 SHALL have parameter RST_VAL, default 0: WIDTH-bit value loaded into out on reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port clr, input, 1 bit: synchronous clear of out and cout.
REQ-006 SHALL have port mode, input, 3 bits: operation select, encodings per REQ-011.
REQ-007 SHALL have port in, input, WIDTH bits: parallel load data.
REQ-008 SHALL have port sin, input, 1 bit: serial input bit for shift modes.
REQ-009 SHALL have port out, output, WIDTH bits: registered register contents.
REQ-010 SHALL have ports cout (output, 1 bit: registered carry/borrow/shifted-out bit) and zero (output, 1 bit: combinational, high when out == 0).

Function
REQ-011 SHALL decode mode as: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 INC, 5 DEC, 6 ROL, 7 ROR.
REQ-012 SHALL update out and cout only on rising clk edge; single-cycle latency from inputs to out.
REQ-013 HOLD: out and cout unchanged.
REQ-014 LOAD: out <= in; cout <= 0.
REQ-015 SHL: out <= {out[WIDTH-2:0], sin}; cout <= old out[WIDTH-1].
REQ-016 SHR: out <= {sin, out[WIDTH-1:1]}; cout <= old out[0].
REQ-017 INC: out <= out + 1 modulo 2^WIDTH; cout <= 1 only when old out is all ones (wrap to 0), else 0.
REQ-018 DEC: out <= out - 1 modulo 2^WIDTH; cout <= 1 only when old out is 0 (wrap to all ones), else 0.
REQ-019 ROL: out <= {out[WIDTH-2:0], out[WIDTH-1]}; cout <= old out[WIDTH-1]; sin ignored.
REQ-020 ROR: out <= {out[0], out[WIDTH-1:1]}; cout <= old out[0]; sin ignored.
REQ-021 clr high SHALL take priority over every mode: out <= 0, cout <= 0 at next edge.
REQ-022 zero SHALL track out combinationally, including immediately after reset and clear.
REQ-023 in SHALL be ignored in all modes except LOAD; sin SHALL be ignored except in SHL/SHR.

Reset
REQ-024 rst low SHALL immediately, without clk, force out = RST_VAL and cout = 0.
REQ-025 rst low SHALL override clr and mode; no state change occurs while rst is low.
REQ-026 rst deassertion SHALL be followed by normal operation at the first rising edge after release; a reset asserted mid-sequence (e.g. during INC run) SHALL discard all progress.

Structure
REQ-027 Mode encodings (MODE_HOLD..MODE_ROR) SHALL be constants in shared package univ_reg_pkg.
REQ-028 SHALL instantiate WIDTH copies of one sub-module univ_reg_cell (1-bit flip-flop with async active-low reset, per-bit reset value, next-value input) via a generate loop.
REQ-029 Next-value, carry and borrow logic SHALL reside in univ_reg at word level; cout SHALL be its own flip-flop with the same reset.
REQ-030 No latches, no combinational loops; zero SHALL be a NOR reduction of out.

Verification (WIDTH=10, RST_VAL=0 unless stated)
REQ-031 rst low mid-cycle with out=0x155 -> out=0x000, cout=0, zero=1 before next edge; RST_VAL=0x2AA build -> out=0x2AA, zero=0.
REQ-032 LOAD in=0x3FF, then INC -> out=0x000, cout=1, zero=1; then DEC -> out=0x3FF, cout=1; then DEC -> out=0x3FE, cout=0.
REQ-033 LOAD 0x201, SHL sin=1 -> out=0x003, cout=1; SHR sin=0 -> out=0x001, cout=1; SHR sin=1 -> out=0x200, cout=1.
REQ-034 LOAD 0x201, ROL -> out=0x003, cout=1; ROR -> out=0x201, cout=1; ten consecutive ROL -> out=0x201.
REQ-035 LOAD 0x0F0 then clr=1 with mode=INC -> out=0x000, cout=0; HOLD with in toggling -> out unchanged.
REQ-036 Random mode/in/sin/clr for 10k cycles with periodic async rst, compared every edge against a reference model of REQ-013..REQ-025.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared constants for the universal register: mode encodings and the mode type.
package univ_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_INC  = 3'd4,
        MODE_DEC  = 3'd5,
        MODE_ROL  = 3'd6,
        MODE_ROR  = 3'd7
    } mode_e;

endpackage

// File: rtl/univ_reg_cell.sv
// One storage bit of the universal register: D flip-flop with async active-low
// reset to a per-bit value.
module univ_reg_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= RST_BIT;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/univ_reg.sv
// Universal register: hold/load/shift/count/rotate over a WIDTH-bit word with a
// registered carry-out and a combinational zero flag.
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int                WIDTH   = 10,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  in,
    input  logic              sin,
    output logic [WIDTH-1:0]  out,
    output logic              cout,
    output logic              zero
);

    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic [WIDTH-1:0] w_next;
    logic             w_nextCout;

    // Word-level next value and carry; clr overrides every mode.
    always_comb begin
        w_next     = r_out;
        w_nextCout = r_cout;
        if (clr) begin
            w_next     = '0;
            w_nextCout = 1'b0;
        end else begin
            case (mode)
                MODE_HOLD: begin
                    w_next     = r_out;
                    w_nextCout = r_cout;
                end
                MODE_LOAD: begin
                    w_next     = in;
                    w_nextCout = 1'b0;
                end
                MODE_SHL: {w_nextCout, w_next} = {r_out, sin};
                MODE_SHR: {w_next, w_nextCout} = {sin, r_out};
                MODE_INC: {w_nextCout, w_next} = {1'b0, r_out} + {{WIDTH{1'b0}}, 1'b1};
                MODE_DEC: begin
                    w_next     = r_out - {{(WIDTH-1){1'b0}}, 1'b1};
                    w_nextCout = (r_out == '0);
                end
                MODE_ROL: begin
                    w_next     = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
                    w_nextCout = r_out[WIDTH-1];
                end
                MODE_ROR: begin
                    w_next     = {r_out[0], r_out[WIDTH-1:1]};
                    w_nextCout = r_out[0];
                end
                default: begin
                    w_next     = r_out;
                    w_nextCout = r_cout;
                end
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        univ_reg_cell #(
            .RST_BIT (RST_VAL[g])
        ) u_cell (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_d     (w_next[g]),
            .o_q     (r_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cout <= 1'b0;
        end else begin
            r_cout <= w_nextCout;
        end
    end

    assign out  = r_out;
    assign cout = r_cout;
    assign zero = ~|r_out;

endmodule
